// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and response-owner encoding for the unified memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch and data request/response ports between requesters and the arbiter
interface unified_mem_arbiter_if;
  import mem_arb_pkg::*;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata
  );
endinterface

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: counts data grants taken while a fetch waits and flags when fetch must win
module mem_arb_starve #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic if_override
);
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (!if_req || if_gnt) ? 4'd0 :
            (d_gnt && cnt_q != 4'(STARVE_MAX)) ? cnt_q + 4'd1 : cnt_q;
    if_override = if_req && cnt_q == 4'(STARVE_MAX);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one RAM2Kx32 between fetch and data ports, data-first with a
// starvation override for fetch; one-deep response pipeline tracks who owns the returning read.
module unified_mem_arbiter import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus,
  output logic                 mem_cen,
  output logic                 mem_wen,
  output logic                 mem_oen,
  output logic [ADDR_W-1:0]    mem_a,
  output logic [DATA_W-1:0]    mem_d,
  input  logic [DATA_W-1:0]    mem_q,
  output logic [15:0]          conflict_cnt
);
  owner_e            own_q, own_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d, d_rd_q, d_rd_d;
  logic [15:0]       cc_q, cc_d;
  logic              if_ovr, if_gnt, d_gnt, grant, if_vld, d_vld;
  mem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (bus.if_req),
    .if_gnt      (if_gnt),
    .d_gnt       (d_gnt),
    .if_override (if_ovr)
  );
  // Grants are gated by rst_n so the combinational outputs drop the moment reset asserts.
  always_comb begin
    d_gnt   = rst_n && bus.d_req && !if_ovr;
    if_gnt  = rst_n && bus.if_req && !d_gnt;
    grant   = d_gnt || if_gnt;
    mem_cen = !grant;
    mem_wen = !(d_gnt && bus.d_we);
    mem_a   = d_gnt ? bus.d_addr : if_gnt ? bus.if_addr : '0;
    mem_d   = grant ? bus.d_wdata : '0;
    own_d   = d_gnt ? OWN_D : if_gnt ? OWN_IF : OWN_NONE;
    we_d    = d_gnt && bus.d_we;
    if_vld  = own_q == OWN_IF;
    d_vld   = own_q == OWN_D;
    mem_oen = !(if_vld || (d_vld && !we_q));
    if_rd_d = if_vld ? mem_q : if_rd_q;
    d_rd_d  = (d_vld && !we_q) ? mem_q : d_rd_q;
    cc_d    = (bus.if_req && bus.d_req && cc_q != 16'hFFFF) ? cc_q + 16'd1 : cc_q;
  end
  assign bus.if_gnt   = if_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.if_valid = if_vld;
  assign bus.d_valid  = d_vld;
  assign bus.if_rdata = if_rd_d;
  assign bus.d_rdata  = d_rd_d;
  assign conflict_cnt = cc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      own_q   <= OWN_NONE;
      we_q    <= 1'b0;
      if_rd_q <= '0;
      d_rd_q  <= '0;
      cc_q    <= '0;
    end else begin
      own_q   <= own_d;
      we_q    <= we_d;
      if_rd_q <= if_rd_d;
      d_rd_q  <= d_rd_d;
      cc_q    <= cc_d;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vectors checked every cycle against a behavioural arbiter model
module tb_unified_mem_arbiter;
  localparam int SM = 3;
  logic        clk, rst_n;
  logic        mem_cen, mem_wen, mem_oen;
  logic [10:0] mem_a;
  logic [31:0] mem_d, mem_q;
  logic [15:0] conflict_cnt;
  logic [31:0] ram [2048];
  logic [31:0] mdl [2048];
  int          n_cmp = 0, n_err = 0;
  int          starve, cc, rown, rwe, raddr;
  logic [31:0] ifh, dh;
  logic [7:0]  pat;

  unified_mem_arbiter_if bus();
  unified_mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q), .conflict_cnt(conflict_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!mem_cen) begin
      if (!mem_wen) ram[mem_a] <= mem_d;
      else mem_q <= ram[mem_a];
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic int who_wins();
    bit fetch_forced;
    fetch_forced = (starve == SM) && bus.if_req;
    if (!rst_n) return 0;
    if (bus.d_req && !fetch_forced) return 2;
    if (bus.if_req) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve = 0; cc = 0; rown = 0; rwe = 0; raddr = 0; ifh = 0; dh = 0;
    end else begin
      int w;
      w = who_wins();
      if (rown == 1) ifh = mdl[raddr];
      if (rown == 2 && rwe == 0) dh = mdl[raddr];
      if (w == 2 && bus.d_we) mdl[bus.d_addr] = bus.d_wdata;
      if (bus.if_req && bus.d_req && cc < 65535) cc++;
      if (!bus.if_req || w == 1) starve = 0;
      else if (w == 2 && starve < SM) starve++;
      rown  = w;
      rwe   = (w == 2 && bus.d_we) ? 1 : 0;
      raddr = (w == 2) ? int'(bus.d_addr) : int'(bus.if_addr);
    end

  always @(negedge clk) begin
    int w;
    bit rd;
    w  = who_wins();
    rd = rown == 1 || (rown == 2 && rwe == 0);
    chk("if_gnt", 32'(bus.if_gnt), 32'(w == 1));
    chk("d_gnt", 32'(bus.d_gnt), 32'(w == 2));
    chk("mem_cen", 32'(mem_cen), 32'(w == 0));
    chk("mem_wen", 32'(mem_wen), 32'(!(w == 2 && bus.d_we)));
    chk("mem_a", 32'(mem_a), w == 2 ? 32'(bus.d_addr) : w == 1 ? 32'(bus.if_addr) : 32'd0);
    chk("mem_d", mem_d, w != 0 ? bus.d_wdata : 32'd0);
    chk("if_valid", 32'(bus.if_valid), 32'(rown == 1));
    chk("d_valid", 32'(bus.d_valid), 32'(rown == 2));
    chk("mem_oen", 32'(mem_oen), 32'(!rd));
    chk("if_rdata", bus.if_rdata, rown == 1 ? mdl[raddr] : ifh);
    chk("d_rdata", bus.d_rdata, (rown == 2 && rwe == 0) ? mdl[raddr] : dh);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(cc));
  end

  typedef struct {
    logic        ir;
    logic [10:0] ia;
    logic        dr;
    logic        dw;
    logic [10:0] da;
    logic [31:0] wd;
  } vec_t;
  vec_t vt [8] = '{
    '{1'b0, 11'h000, 1'b1, 1'b1, 11'h020, 32'hA5A5_0001},
    '{1'b1, 11'h020, 1'b1, 1'b1, 11'h021, 32'h0BAD_F00D},
    '{1'b1, 11'h021, 1'b0, 1'b0, 11'h000, 32'h0000_0000},
    '{1'b1, 11'h010, 1'b1, 1'b0, 11'h020, 32'hFFFF_FFFF},
    '{1'b0, 11'h000, 1'b1, 1'b0, 11'h004, 32'h0000_0000},
    '{1'b1, 11'h004, 1'b1, 1'b1, 11'h7FF, 32'h8000_0001},
    '{1'b1, 11'h7FF, 1'b0, 1'b0, 11'h000, 32'h0000_0000},
    '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 32'h0000_0000}
  };

  initial begin
    rst_n = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 11'h004; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("first_gnt_after_reset", 32'(bus.d_gnt), 32'd1);
    @(posedge clk); #2;
    bus.d_req = 0; bus.d_we = 0; bus.if_req = 1; bus.if_addr = 11'h004;
    @(negedge clk);
    chk("fetch_gnt_n", 32'(bus.if_gnt), 32'd1);
    @(posedge clk); #2 bus.if_req = 0;
    @(negedge clk);
    chk("fetch_valid_n1", 32'(bus.if_valid), 32'd1);
    chk("fetch_rdata_n1", bus.if_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #2;
    @(negedge clk);
    chk("fetch_rdata_hold", bus.if_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #2;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 11'h010; bus.d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_wen_low", 32'(mem_wen), 32'd0);
    @(posedge clk); #2 bus.d_we = 0;
    @(negedge clk);
    chk("wr_ack_valid", 32'(bus.d_valid), 32'd1);
    chk("wr_ack_rdata_unchanged", bus.d_rdata, 32'd0);
    chk("wr_ack_oen", 32'(mem_oen), 32'd1);
    @(posedge clk); #2 bus.d_req = 0;
    @(negedge clk);
    chk("rd_valid", 32'(bus.d_valid), 32'd1);
    chk("rd_rdata", bus.d_rdata, 32'h1234_5678);
    @(posedge clk); #2;
    bus.if_req = 1; bus.if_addr = 11'h004; bus.d_req = 1; bus.d_addr = 11'h010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) pat[i] = bus.d_gnt;
      @(posedge clk); #2;
    end
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    chk("contention_seq", 32'(pat), 32'h77);
    chk("contention_cnt", 32'(conflict_cnt), 32'd8);
    @(posedge clk); #2 bus.if_req = 1; bus.d_req = 1;
    repeat (70000) @(posedge clk);
    #2 bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    chk("conflict_saturated", 32'(conflict_cnt), 32'h0000_FFFF);
    @(posedge clk); #2 bus.if_req = 1; bus.if_addr = 11'h004;
    @(posedge clk); #2 bus.if_req = 0; rst_n = 0;
    @(negedge clk);
    chk("reset_drops_valid", 32'(bus.if_valid), 32'd0);
    chk("reset_cnt", 32'(conflict_cnt), 32'd0);
    chk("reset_cen", 32'(mem_cen), 32'd1);
    chk("reset_oen", 32'(mem_oen), 32'd1);
    chk("reset_if_rdata", bus.if_rdata, 32'd0);
    @(posedge clk); #2 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      bus.if_req = vt[i].ir; bus.if_addr = vt[i].ia; bus.d_req = vt[i].dr;
      bus.d_we = vt[i].dw; bus.d_addr = vt[i].da; bus.d_wdata = vt[i].wd;
      @(posedge clk); #2;
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
